// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and selectable standard or first-word-fall-through reads.
module sync_fifo_gen #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       we,
  input  logic [DATA_W-1:0]          din,
  input  logic                       re,
  input  logic                       clr_err,
  output logic [DATA_W-1:0]          dout,
  output logic                       d_full,
  output logic                       d_empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // Flags come only from the count register, never from we/re.
  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_acc = we && !w_full;
  assign w_rd_acc = re && !w_empty;

  // Storage is deliberately unreset; zeroed pointers make stale data unreachable.
  always_ff @(posedge clk) begin
    if (w_wr_acc && nrst) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A fresh error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (we && w_full)  || (r_overflow  && !clr_err);
      r_underflow <= (re && w_empty) || (r_underflow && !clr_err);
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign dout = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [DATA_W-1:0] r_dout;
      always_ff @(posedge clk) begin
        if (!nrst) begin
          r_dout <= '0;
        end else if (w_rd_acc) begin
          r_dout <= r_mem[r_rd_ptr];
        end
      end
      assign dout = r_dout;
    end
  endgenerate

  assign d_full       = w_full;
  assign d_empty      = w_empty;
  assign almost_full  = (r_count >= CW'(AF_THRESH));
  assign almost_empty = (r_count <= CW'(AE_THRESH));
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Directed bench for sync_fifo_gen: a standard-read and an FWFT instance share
// one stimulus stream; vectors table plus hand sequences for multi-cycle corners.
module tb_sync_fifo_gen;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] o0_dout, o1_dout;
  logic       o0_full, o0_empty, o0_af, o0_ae, o0_ovf, o0_udf;
  logic       o1_full, o1_empty, o1_af, o1_ae, o1_ovf, o1_udf;
  logic [4:0] o0_count, o1_count;

  int n_pass = 0;
  int n_chk  = 0;

  sync_fifo_gen #(.DATA_W(8), .DEPTH(16), .FWFT(1'b0)) u_std (
    .clk(clk), .nrst(nrst), .we(we), .din(din), .re(re), .clr_err(clr_err),
    .dout(o0_dout), .d_full(o0_full), .d_empty(o0_empty),
    .almost_full(o0_af), .almost_empty(o0_ae), .count(o0_count),
    .overflow(o0_ovf), .underflow(o0_udf)
  );

  sync_fifo_gen #(.DATA_W(8), .DEPTH(16), .FWFT(1'b1)) u_fwft (
    .clk(clk), .nrst(nrst), .we(we), .din(din), .re(re), .clr_err(clr_err),
    .dout(o1_dout), .d_full(o1_full), .d_empty(o1_empty),
    .almost_full(o1_af), .almost_empty(o1_ae), .count(o1_count),
    .overflow(o1_ovf), .underflow(o1_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [7:0] din;
    logic       re;
    logic       clr;
    logic [18:0] exp;
  } vec_t;

  vec_t tv[38];

  // Packing: {count[4:0], full, empty, af, ae, ovf, udf, dout[7:0]}
  function automatic logic [18:0] ex(int cnt, logic ovf, logic udf, logic [7:0] dv);
    logic [4:0] c;
    c = 5'(cnt);
    return {c, (cnt == 16), (cnt == 0), (cnt >= 14), (cnt <= 2), ovf, udf, dv};
  endfunction

  function automatic logic [18:0] snap0();
    return {o0_count, o0_full, o0_empty, o0_af, o0_ae, o0_ovf, o0_udf, o0_dout};
  endfunction

  function automatic vec_t mk(logic w, logic [7:0] d, logic r, logic c, logic [18:0] e);
    vec_t v;
    v.we = w; v.din = d; v.re = r; v.clr = c; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    @(negedge clk);
    we = w; din = d; re = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0; we = 1'b0; re = 1'b0; clr_err = 1'b0; din = 8'h00;
    @(posedge clk);
    #1;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    // Fill 1..16, overflow, clear, drain 16, underflow, clear, empty corner cases.
    for (int i = 0; i < 16; i++)
      tv[i] = mk(1'b1, 8'(i + 1), 1'b0, 1'b0, ex(i + 1, 1'b0, 1'b0, 8'h00));
    tv[16] = mk(1'b1, 8'hAA, 1'b0, 1'b0, ex(16, 1'b1, 1'b0, 8'h00));
    tv[17] = mk(1'b0, 8'h00, 1'b0, 1'b1, ex(16, 1'b0, 1'b0, 8'h00));
    for (int k = 0; k < 16; k++)
      tv[18 + k] = mk(1'b0, 8'h00, 1'b1, 1'b0, ex(15 - k, 1'b0, 1'b0, 8'(k + 1)));
    tv[34] = mk(1'b0, 8'h00, 1'b1, 1'b0, ex(0, 1'b0, 1'b1, 8'd16));
    tv[35] = mk(1'b0, 8'h00, 1'b0, 1'b1, ex(0, 1'b0, 1'b0, 8'd16));
    tv[36] = mk(1'b1, 8'h77, 1'b1, 1'b0, ex(1, 1'b0, 1'b1, 8'd16));
    tv[37] = mk(1'b0, 8'h00, 1'b1, 1'b1, ex(0, 1'b0, 1'b0, 8'h77));

    do_reset();
    chk("reset_std", 32'(snap0()), 32'(ex(0, 1'b0, 1'b0, 8'h00)));
    chk("reset_fwft_dout", 32'(o1_dout), 32'h0);

    for (int i = 0; i < 38; i++) begin
      cyc(tv[i].we, tv[i].din, tv[i].re, tv[i].clr);
      chk($sformatf("vec%0d", i), 32'(snap0()), 32'(tv[i].exp));
    end

    // Steady-state simultaneous read/write across pointer wrap.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 8'(9 + k), 1'b1, 1'b0);
      chk($sformatf("tput_count%0d", k), 32'(o0_count), 32'd8);
      chk($sformatf("tput_dout%0d", k), 32'(o0_dout), 32'(k + 1));
    end

    // First-word-fall-through behaviour.
    do_reset();
    cyc(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("fwft_fall", 32'(o1_dout), 32'h5A);
    cyc(1'b1, 8'h5B, 1'b0, 1'b0);
    chk("fwft_hold", 32'({o1_count, o1_dout}), 32'({5'd2, 8'h5A}));
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_pop", 32'(o1_dout), 32'h5B);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_empty", 32'({o1_empty, o1_dout}), 32'({1'b1, 8'h00}));

    // Full with simultaneous read: write dropped, read accepted.
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("full_set", 32'(o0_full), 32'd1);
    cyc(1'b1, 8'hCC, 1'b1, 1'b0);
    chk("full_rw", 32'({o0_count, o0_full, o0_ovf, o0_dout}), 32'({5'd15, 1'b0, 1'b1, 8'h10}));
    cyc(1'b1, 8'hDD, 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1);
    chk("clr_vs_set", 32'({o0_count, o0_ovf}), 32'({5'd16, 1'b1}));
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("clr_ovf", 32'(o0_ovf), 32'd0);
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("drain%0d", k), 32'(o0_dout), (k < 15) ? 32'(8'h11 + k) : 32'hDD);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("udf_clr_vs_set", 32'(o0_udf), 32'd1);

    // Reset mid-operation with a concurrent write.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst", 32'({o0_count, o0_dout}), 32'({5'd4, 8'h01}));
    @(negedge clk);
    nrst = 1'b0; we = 1'b1; din = 8'h99; re = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_std", 32'(snap0()), 32'(ex(0, 1'b0, 1'b0, 8'h00)));
    chk("midrst_fwft", 32'({o1_count, o1_empty, o1_dout}), 32'({5'd0, 1'b1, 8'h00}));
    @(negedge clk);
    nrst = 1'b1; we = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_write_ignored", 32'({o0_count, o1_dout}), 32'({5'd0, 8'h00}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sync_fifo_gen.md
# sync_fifo_gen

Parametrised synchronous FIFO: the next-generation replacement for the fixed 8-bit `sync_fifo`, generalised in data width and depth. It adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a selectable first-word-fall-through read mode. It sits between any two blocks in a single clock domain as a general-purpose elastic buffer.

## Interface
- `DATA_W`, 8: data width in bits, ≥1.
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `AF_THRESH`, DEPTH-2: `almost_full` asserts when count ≥ AF_THRESH; range 1..DEPTH.
- `AE_THRESH`, 2: `almost_empty` asserts when count ≤ AE_THRESH; range 0..DEPTH-1.
- `FWFT`, 0: read mode. 0 = standard (registered read data). 1 = first-word-fall-through.

Ports:
- `clk` in 1: clock, rising edge.
- `nrst` in 1: synchronous active-low reset.
- `we` in 1: write request.
- `din` in DATA_W: write data.
- `re` in 1: read request.
- `clr_err` in 1: clears `overflow` and `underflow`.
- `dout` out DATA_W: read data.
- `d_full` out 1: count == DEPTH.
- `d_empty` out 1: count == 0.
- `almost_full` out 1: count ≥ AF_THRESH.
- `almost_empty` out 1: count ≤ AE_THRESH.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky; a write was attempted while full.
- `underflow` out 1: sticky; a read was attempted while empty.

## Operation
- Write accept: `we && !d_full`. The block stores `din` at `wr_ptr`, and `wr_ptr` increments.
- Read accept: `re && !d_empty`. `rd_ptr` increments.
- A write to a full FIFO is dropped, even if a read is accepted in the same cycle. A read from an empty FIFO is dropped, even if a write is accepted in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Count update:
  - +1 on an accepted write only.
  - −1 on an accepted read only.
  - Unchanged when both are accepted, or when neither is.
- All flags decode combinationally from the `count` register.
- FWFT=0:
  - `dout` is a register, loaded with mem[rd_ptr] on an accepted read.
  - `dout` holds its value otherwise, including on rejected reads.
- FWFT=1:
  - `dout` = mem[rd_ptr] whenever `!d_empty`, and 0 when empty.
  - An accepted read pops the entry; `dout` shows the next entry after the edge.
- `overflow` sets on any edge where `we && d_full`. `underflow` sets on any edge where `re && d_empty`.
- `clr_err` clears both error flags. If a new error occurs in the same cycle as `clr_err`, set wins.
- Memory array is not reset. Content is unreachable after reset because the pointers are zeroed.

## Timing
- Reset (`nrst` = 0 at a rising edge) gives these outputs after that edge:
  - `wr_ptr`, `rd_ptr`, `count` = 0.
  - `dout` = 0.
  - `d_empty` = 1, `almost_empty` = 1.
  - `d_full` = 0, `almost_full` = 0.
  - `overflow` = 0, `underflow` = 0.
- Reset overrides `we`, `re` and `clr_err` in the same cycle.
- Reset mid-operation discards all stored entries.
- Flags and `count` change in the cycle after the accepting edge. There is no combinational path from `we`/`re` to any flag.
- FWFT=0 read latency: `dout` is valid one cycle after the edge where the read is accepted.
- FWFT=1 latency: a write into an empty FIFO appears on `dout` one cycle after the write edge.
- Write-to-read latency is 1 cycle minimum. An entry written at edge N can be accepted for read at edge N+1.
- Full throughput: simultaneous accepted read and write every cycle at any non-empty, non-full level.

## Test plan
- Reset, then write 1..16 (DEPTH=16, DATA_W=8, FWFT=0) → `count` steps 1..16; `almost_full` rises after the 14th write; `d_full` rises after the 16th; `d_empty` = 0 after the 1st.
- From full, a 17th write of 0xAA → data dropped; `overflow` = 1 next cycle; `count` stays 16. Then pulse `clr_err` → `overflow` = 0.
- From full, read 16 times → `dout` = 1..16 in order, each one cycle after its read edge; `d_empty` = 1 after the last read. A further `re` → `underflow` = 1 and `dout` holds 16.
- Write 8 entries, then 20 cycles of simultaneous `we`/`re` with din = 9..28 → `count` holds 8; reads return 1..20 in order across the pointer wrap.
- FWFT=1: write 0x5A into an empty FIFO → `dout` = 0x5A one cycle later with no `re`. Write 0x5B, then `re` → `dout` = 0x5B the next cycle.
- Write 5 entries, then assert `nrst` = 0 for one edge while `we` = 1 → `count` = 0, `d_empty` = 1, `dout` = 0, and the write is ignored.
